// File: rtl/bf8b_mem_arbiter_pkg.sv
// Shared owner-tag encoding and helpers for the bf8b memory arbiter,
// the fetch unit and the load/store unit.
package bf8b_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned STREAK_W = 4;

  // Owner of the response that follows a grant cycle.
  function automatic owner_t next_owner(input logic i_gnt, input logic d_gnt);
    if (d_gnt) begin
      return OWN_D;
    end
    if (i_gnt) begin
      return OWN_I;
    end
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/bf8b_arb_streak_ctr.sv
// Fair-mode helper: counts D grants taken while a fetch is waiting and
// forces the fetch port through once the streak limit is reached (MEM_ARB_FAIR_EN).
`ifdef MEM_ARB_FAIR_EN
module bf8b_arb_streak_ctr
  import bf8b_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_i_c
);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  // Streak only grows while the fetch side is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (i_gnt || !i_req) begin
      streak_d = '0;
    end else if (d_gnt) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_i_c = i_req && (streak_q == STREAK_W'(MAX_DSTREAK));

endmodule
`endif

// File: rtl/bf8b_mem_arbiter.sv
// Single-port memory arbiter between fetch (I) and load/store (D) ports.
// Define MEM_ARB_FAIR_EN to bound D-over-I starvation by MAX_DSTREAK grants.
module bf8b_mem_arbiter
  import bf8b_mem_arbiter_pkg::*;
#(
  parameter int unsigned A_WIDTH     = 30,
  parameter int unsigned M_WIDTH     = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [A_WIDTH-1:0]     i_addr,
  input  logic                   i_kill,
  output logic                   i_gnt,
  output logic                   i_rvalid,
  output logic [M_WIDTH-1:0]     i_rdata,
  input  logic                   d_req,
  input  logic [A_WIDTH-1:0]     d_addr,
  input  logic [M_WIDTH/8-1:0]   d_wes,
  input  logic [M_WIDTH-1:0]     d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [M_WIDTH-1:0]     d_rdata,
  output logic [A_WIDTH-1:0]     m_addr,
  output logic [M_WIDTH-1:0]     m_wdata,
  output logic [M_WIDTH/8-1:0]   m_wes,
  input  logic [M_WIDTH-1:0]     m_rdata
);

  if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15) begin : g_bad_streak
    $error("MAX_DSTREAK must be in 1..15");
  end

  owner_t             owner_q;
  logic [A_WIDTH-1:0] addr_q;
  logic               force_i_c;

`ifdef MEM_ARB_FAIR_EN
  bf8b_arb_streak_ctr #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_streak_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_gnt    (i_gnt),
    .d_gnt    (d_gnt),
    .force_i_c(force_i_c)
  );
`else
  assign force_i_c = 1'b0;
`endif

  // Grant: D wins unless the streak limit forces I; nothing while in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (i_req && (force_i_c || !d_req)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory command from the winner; address holds when idle.
  always_comb begin
    m_addr  = addr_q;
    m_wes   = '0;
    m_wdata = d_wdata;
    if (d_gnt) begin
      m_addr = d_addr;
      m_wes  = d_wes;
    end else if (i_gnt) begin
      m_addr = i_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      addr_q  <= '0;
    end else begin
      owner_q <= next_owner(i_gnt, d_gnt);
      addr_q  <= m_addr;
    end
  end

  // Memory data is shared by both ports; only the valids are steered.
  assign i_rvalid = (owner_q == OWN_I) && !i_kill;
  assign d_rvalid = (owner_q == OWN_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_bf8b_mem_arbiter.sv
// Randomised + directed bench for bf8b_mem_arbiter against a behavioural
// arbitration/memory model (honours MEM_ARB_FAIR_EN).
module tb_bf8b_mem_arbiter;

  localparam int unsigned A_WIDTH     = 30;
  localparam int unsigned M_WIDTH     = 32;
  localparam int unsigned WES_W       = M_WIDTH / 8;
  localparam int unsigned MAX_DSTREAK = 4;
  localparam int unsigned N_WORDS     = 256;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR_MODE = 1'b1;
`else
  localparam bit FAIR_MODE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_req, i_kill, i_gnt, i_rvalid;
  logic [A_WIDTH-1:0] i_addr;
  logic [M_WIDTH-1:0] i_rdata;
  logic               d_req, d_gnt, d_rvalid;
  logic [A_WIDTH-1:0] d_addr;
  logic [WES_W-1:0]   d_wes;
  logic [M_WIDTH-1:0] d_wdata, d_rdata;
  logic [A_WIDTH-1:0] m_addr;
  logic [M_WIDTH-1:0] m_wdata, m_rdata;
  logic [WES_W-1:0]   m_wes;

  int n_checks = 0;
  int n_errors = 0;
  int rst_falls = 0;

  bf8b_mem_arbiter #(
    .A_WIDTH(A_WIDTH), .M_WIDTH(M_WIDTH), .MAX_DSTREAK(MAX_DSTREAK)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wes(d_wes), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wes(m_wes), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;
  always @(negedge rst) rst_falls++;

  function automatic logic [31:0] init_word(input int unsigned a);
    return 32'h1234_5678 + 32'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // External memory: 1-cycle read latency, read-first, byte writes.
  logic [31:0] mem [N_WORDS];
  initial begin : memory
    logic [7:0]       lat_idx;
    logic [WES_W-1:0] lat_wes;
    logic [31:0]      lat_wdata;
    for (int i = 0; i < int'(N_WORDS); i++) mem[i] = init_word(i);
    m_rdata = '0;
    forever begin
      @(negedge clk);
      lat_idx   = m_addr[7:0];
      lat_wes   = m_wes;
      lat_wdata = m_wdata;
      @(posedge clk);
      m_rdata <= mem[lat_idx];
      if (rst) begin
        for (int b = 0; b < int'(WES_W); b++)
          if (lat_wes[b]) mem[lat_idx][8*b +: 8] = lat_wdata[8*b +: 8];
      end
    end
  end

  // Reference model and per-cycle compare.
  logic [31:0] ref_mem [N_WORDS];
  initial begin : compare
    int unsigned        streak;
    int                 seen_falls, pend_own, exp_own, gnt_own;
    logic [7:0]         pend_idx;
    logic [WES_W-1:0]   pend_wes;
    logic [31:0]        pend_wdata, exp_rdata;
    logic [A_WIDTH-1:0] last_addr, exp_maddr;
    streak = 0; seen_falls = 0; pend_own = 0; pend_idx = '0;
    pend_wes = '0; pend_wdata = '0; last_addr = '0;
    for (int i = 0; i < int'(N_WORDS); i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!rst || rst_falls != seen_falls) begin
        seen_falls = rst_falls;
        pend_own = 0; streak = 0; last_addr = '0;
      end
      exp_own   = pend_own;
      exp_rdata = ref_mem[pend_idx];
      if (pend_own == 2)
        for (int b = 0; b < int'(WES_W); b++)
          if (pend_wes[b]) ref_mem[pend_idx][8*b +: 8] = pend_wdata[8*b +: 8];
      check("i_rvalid", 32'(i_rvalid), 32'(exp_own == 1 && !i_kill));
      check("d_rvalid", 32'(d_rvalid), 32'(exp_own == 2));
      if (exp_own == 1 && !i_kill) check("i_rdata", i_rdata, exp_rdata);
      if (exp_own == 2 && pend_wes == '0) check("d_rdata", d_rdata, exp_rdata);

      gnt_own = 0;
      if (rst) begin
        if (FAIR_MODE && i_req && streak == MAX_DSTREAK) gnt_own = 1;
        else if (d_req) gnt_own = 2;
        else if (i_req) gnt_own = 1;
      end
      if (gnt_own == 1 || !i_req) streak = 0;
      else if (gnt_own == 2) streak++;

      exp_maddr = (gnt_own == 2) ? d_addr : (gnt_own == 1) ? i_addr : last_addr;
      check("i_gnt", 32'(i_gnt), 32'(gnt_own == 1));
      check("d_gnt", 32'(d_gnt), 32'(gnt_own == 2));
      check("m_addr", 32'(m_addr), 32'(exp_maddr));
      check("m_wes", 32'(m_wes), (gnt_own == 2) ? 32'(d_wes) : 32'd0);
      if (gnt_own == 2 && d_wes != '0) check("m_wdata", m_wdata, d_wdata);

      last_addr  = exp_maddr;
      pend_own   = gnt_own;
      pend_idx   = exp_maddr[7:0];
      pend_wes   = (gnt_own == 2) ? d_wes : '0;
      pend_wdata = d_wdata;
    end
  end

  // Stimulus with a few hand-computed expectations.
  initial begin : stim
    logic [9:0] seq;
    logic [9:0] exp_seq;
    logic       gi, gd;
    i_req = 0; i_addr = '0; i_kill = 0; d_req = 0; d_addr = '0; d_wes = '0; d_wdata = '0;

    // Reset held with both requests up.
    step(); i_req = 1; i_addr = 30'h10; d_req = 1; d_addr = 30'h20;
    @(negedge clk);
    check("rst_i_gnt", 32'(i_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    step(); rst = 1;
    @(negedge clk);
    check("rel_d_gnt", 32'(d_gnt), 32'd1);
    step(); d_req = 0;
    @(negedge clk);
    check("rel_i_gnt", 32'(i_gnt), 32'd1);
    step(); i_req = 0;
    step();

    // Back-to-back fetches 0x10..0x13.
    i_req = 1; i_addr = 30'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ionly_gnt", 32'(i_gnt), 32'd1);
      if (k > 0) check("ionly_rdata", i_rdata, 32'h1234_5688 + 32'(k - 1));
      step();
      if (k < 3) i_addr = 30'(32'h11 + 32'(k));
      else i_req = 0;
    end
    @(negedge clk);
    check("ionly_last_rdata", i_rdata, 32'h1234_568B);

    // Collision with a half-word store, then read it back.
    step(); i_req = 1; i_addr = 30'h40; d_req = 1; d_addr = 30'h38;
    d_wes = 4'b0011; d_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    check("coll_d_gnt", 32'(d_gnt), 32'd1);
    step(); d_req = 0; d_wes = '0;
    @(negedge clk);
    check("coll_i_gnt", 32'(i_gnt), 32'd1);
    step(); i_req = 0; d_req = 1; d_addr = 30'h38;
    @(negedge clk);
    check("coll_i_rdata", i_rdata, 32'h1234_56B8);
    step(); d_req = 0;
    @(negedge clk);
    check("coll_readback", d_rdata, 32'h1234_CCDD);

    // Both held for ten cycles.
    step(); i_req = 1; i_addr = 30'h5; d_req = 1; d_addr = 30'h6;
    seq = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seq[k] = i_gnt;
      step();
    end
    exp_seq = FAIR_MODE ? 10'b10_0001_0000 : 10'b00_0000_0000;
    check("fair_seq", 32'(seq), 32'(exp_seq));
    i_req = 0; d_req = 0;
    step();

    // Kill the fetch response while a load is granted.
    i_req = 1; i_addr = 30'h22;
    @(negedge clk);
    check("kill_i_gnt", 32'(i_gnt), 32'd1);
    step(); i_req = 0; i_kill = 1; d_req = 1; d_addr = 30'h23;
    @(negedge clk);
    check("kill_i_rvalid", 32'(i_rvalid), 32'd0);
    step(); i_kill = 0; d_req = 0;
    @(negedge clk);
    check("kill_d_rdata", d_rdata, 32'h1234_569B);

    // Reset between grant and response.
    step(); d_req = 1; d_addr = 30'h30;
    @(negedge clk);
    check("mid_d_gnt", 32'(d_gnt), 32'd1);
    #1 rst = 0;
    step(); d_req = 0;
    @(negedge clk);
    check("mid_d_rvalid", 32'(d_rvalid), 32'd0);
    step(); rst = 1; d_req = 1; d_addr = 30'h31;
    step(); d_req = 0;
    @(negedge clk);
    check("mid_post_rdata", d_rdata, 32'h1234_56A9);
    step();

    // Random traffic obeying the hold-until-grant protocol.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gi = i_gnt;
      gd = d_gnt;
      if (rst && $urandom_range(0, 999) < 4) #1 rst = 0;
      step();
      if (!rst) rst = 1;
      if (!i_req || gi) begin
        i_req  = ($urandom_range(0, 99) < 60);
        i_addr = 30'($urandom);
      end else if ($urandom_range(0, 99) < 10) begin
        i_req = 0;
      end
      if (!d_req || gd) begin
        d_req   = ($urandom_range(0, 99) < 55);
        d_addr  = 30'($urandom);
        d_wes   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
        d_wdata = $urandom;
      end
      i_kill = ($urandom_range(0, 99) < 25);
    end
    step(); i_req = 0; d_req = 0; i_kill = 0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
